// File: rtl/word_demux_1_4_if.sv
`default_nettype none
// ============================================================================
//  Module      : word_demux_1_4_if
//  Description : Bundle of the word demultiplexer's data-in, control and
//                channel-status signals. The master modport drives words in and
//                observes channels. The slave modport is the demux itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface word_demux_1_4_if #(
    parameter int CNT_W = 8
);
    logic [15:0]      din;
    logic             din_valid;
    logic             din_perr;
    logic [1:0]       adr;
    logic             auto;
    logic [3:0]       rd_ack;
    logic             ovr_clr;

    logic [15:0]      A;
    logic [15:0]      B;
    logic [15:0]      C;
    logic [15:0]      D;
    logic [3:0]       full;
    logic [3:0]       overrun;
    logic [1:0]       ptr;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output din, din_valid, din_perr, adr, auto, rd_ack, ovr_clr,
        input  A, B, C, D, full, overrun, ptr, err_cnt
    );

    modport slave (
        input  din, din_valid, din_perr, adr, auto, rd_ack, ovr_clr,
        output A, B, C, D, full, overrun, ptr, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/word_demux_1_4.sv
`default_nettype none
// ============================================================================
//  Module      : word_demux_1_4
//  Description : Steers incoming 16-bit words into one of four holding
//                registers (A..D). The destination comes from adr, or from an
//                internal round-robin pointer when auto=1. The module tracks
//                per-channel full/overrun flags and counts parity-error words,
//                saturating at the maximum count.
//  Option      : DEMUX_OVERWRITE_EN - when defined, a write to a full channel
//                replaces the held word. When undefined, the new word is
//                dropped and the older word is kept.
//  Revision    : 1.0  initial release
// ============================================================================
module word_demux_1_4 #(
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    word_demux_1_4_if.slave        bus
);

    logic [15:0]      data_q [4];
    logic [15:0]      data_d [4];
    logic [3:0]       full_q;
    logic [3:0]       full_d;
    logic [3:0]       overrun_q;
    logic [3:0]       overrun_d;
    logic [1:0]       ptr_q;
    logic [1:0]       ptr_d;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] err_cnt_d;

    logic [1:0]       w_sel;
    logic             w_accept;
    logic             w_perr;
    logic [3:0]       w_wr;
    logic [3:0]       w_ovr_ev;

    assign w_sel    = bus.auto ? ptr_q : bus.adr;
    assign w_accept = bus.din_valid & ~bus.din_perr;
    assign w_perr   = bus.din_valid &  bus.din_perr;

    // Next-state computation.
    // A write beats a same-cycle acknowledge on the same channel.
    // An overrun event beats ovr_clr.
    always_comb begin
        ptr_d     = ptr_q;
        err_cnt_d = err_cnt_q;
        for (int n = 0; n < 4; n++) begin
            w_wr[n]     = w_accept && (w_sel == 2'(n));
            w_ovr_ev[n] = w_wr[n] && full_q[n] && !bus.rd_ack[n];
            data_d[n]   = data_q[n];
            if (w_wr[n] && !w_ovr_ev[n]) begin
                data_d[n] = bus.din;
            end
`ifdef DEMUX_OVERWRITE_EN
            if (w_ovr_ev[n]) begin
                data_d[n] = bus.din;
            end
`endif
            full_d[n]    = w_wr[n] | (full_q[n] & ~bus.rd_ack[n]);
            overrun_d[n] = w_ovr_ev[n] | (overrun_q[n] & ~bus.ovr_clr);
        end
        // The pointer advances on every accepted word, including dropped overruns.
        if (w_accept && bus.auto) begin
            ptr_d = ptr_q + 2'd1;
        end
        if (w_perr && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    // State registers. Reset overrides everything, including a word arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 4; n++) begin
                data_q[n] <= 16'h0000;
            end
            full_q    <= 4'b0000;
            overrun_q <= 4'b0000;
            ptr_q     <= 2'd0;
            err_cnt_q <= '0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                data_q[n] <= data_d[n];
            end
            full_q    <= full_d;
            overrun_q <= overrun_d;
            ptr_q     <= ptr_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.A       = data_q[0];
    assign bus.B       = data_q[1];
    assign bus.C       = data_q[2];
    assign bus.D       = data_q[3];
    assign bus.full    = full_q;
    assign bus.overrun = overrun_q;
    assign bus.ptr     = ptr_q;
    assign bus.err_cnt = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_word_demux_1_4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_word_demux_1_4
//  Description : Self-checking bench for word_demux_1_4. The error counter is
//                kept narrow so that it saturates. Directed vectors come from
//                a table, followed by random traffic checked against a
//                channel-level model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_word_demux_1_4;

    localparam int CNT_W   = 2;
    localparam int ERR_MAX = (1 << CNT_W) - 1;
`ifdef DEMUX_OVERWRITE_EN
    localparam bit OVERWRITE = 1'b1;
`else
    localparam bit OVERWRITE = 1'b0;
`endif
    localparam logic [15:0] B_AFTER_2 = OVERWRITE ? 16'h2222 : 16'h1111;
    localparam logic [15:0] B_AFTER_3 = OVERWRITE ? 16'h3333 : 16'h1111;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    word_demux_1_4_if #(.CNT_W(CNT_W)) bus ();

    word_demux_1_4 #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        r;
        logic [15:0] d;
        logic        v;
        logic        p;
        logic [1:0]  a;
        logic        au;
        logic [3:0]  k;
        logic        oc;
        logic [3:0]  e_full;
        logic [3:0]  e_ovr;
        logic [1:0]  e_ptr;
        int          e_err;
        int          e_ch;
        logic [15:0] e_word;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_mis = 0;

    // Channel-level model.
    logic [15:0] m_data [4];
    logic [3:0]  m_full;
    logic [3:0]  m_ovr;
    int          m_ptr;
    int          m_err;

    function automatic logic [15:0] dut_ch(input int n);
        case (n)
            0:       return bus.A;
            1:       return bus.B;
            2:       return bus.C;
            default: return bus.D;
        endcase
    endfunction

    task automatic model_step(input logic r, input logic [15:0] d, input logic v,
                              input logic p, input logic [1:0] a, input logic au,
                              input logic [3:0] k, input logic oc);
        int dest;
        logic [3:0] nf, no;
        if (r) begin
            for (int n = 0; n < 4; n++) m_data[n] = 16'h0000;
            m_full = 4'b0000;
            m_ovr  = 4'b0000;
            m_ptr  = 0;
            m_err  = 0;
            return;
        end
        dest = au ? m_ptr : int'(a);
        nf   = m_full & ~k;
        no   = oc ? 4'b0000 : m_ovr;
        if (v && p) begin
            if (m_err < ERR_MAX) m_err = m_err + 1;
        end else if (v) begin
            if (m_full[dest] && !k[dest]) begin
                no[dest] = 1'b1;
                if (OVERWRITE) m_data[dest] = d;
            end else begin
                m_data[dest] = d;
            end
            nf[dest] = 1'b1;
            if (au) m_ptr = (m_ptr + 1) % 4;
        end
        m_full = nf;
        m_ovr  = no;
    endtask

    task automatic drive(input logic r, input logic [15:0] d, input logic v,
                         input logic p, input logic [1:0] a, input logic au,
                         input logic [3:0] k, input logic oc);
        rst           = r;
        bus.din       = d;
        bus.din_valid = v;
        bus.din_perr  = p;
        bus.adr       = a;
        bus.auto      = au;
        bus.rd_ack    = k;
        bus.ovr_clr   = oc;
        @(posedge clk);
        model_step(r, d, v, p, a, au, k, oc);
        #1;
    endtask

    task automatic check_model(input string name);
        bit bad = 1'b0;
        n_vec++;
        for (int n = 0; n < 4; n++) if (dut_ch(n) !== m_data[n]) bad = 1'b1;
        if (bus.full !== m_full || bus.overrun !== m_ovr ||
            bus.ptr !== 2'(m_ptr) || bus.err_cnt !== CNT_W'(m_err)) bad = 1'b1;
        if (bad) begin
            n_mis++;
            $display("FAIL %s: got A=%h B=%h C=%h D=%h full=%b ovr=%b ptr=%0d err=%0d; expected A=%h B=%h C=%h D=%h full=%b ovr=%b ptr=%0d err=%0d",
                     name, bus.A, bus.B, bus.C, bus.D, bus.full, bus.overrun, bus.ptr, bus.err_cnt,
                     m_data[0], m_data[1], m_data[2], m_data[3], m_full, m_ovr, m_ptr, m_err);
        end
    endtask

    function automatic void add(input logic r, input logic [15:0] d, input logic v,
                                input logic p, input logic [1:0] a, input logic au,
                                input logic [3:0] k, input logic oc,
                                input logic [3:0] ef, input logic [3:0] eo,
                                input logic [1:0] ep, input int ee,
                                input int ech, input logic [15:0] ew);
        vec_t t;
        t.r = r; t.d = d; t.v = v; t.p = p; t.a = a; t.au = au; t.k = k; t.oc = oc;
        t.e_full = ef; t.e_ovr = eo; t.e_ptr = ep; t.e_err = ee; t.e_ch = ech; t.e_word = ew;
        tbl.push_back(t);
    endfunction

    initial begin
        //   rst din      vld perr adr au ack     oclr | full    ovr     ptr err ch word
        add(1, 16'h0000, 0, 0, 0, 0, 4'b0000, 0,  4'b0000, 4'b0000, 0, 0, 0, 16'h0000); // reset
        add(0, 16'hA5A5, 1, 0, 2, 0, 4'b0000, 0,  4'b0100, 4'b0000, 0, 0, 2, 16'hA5A5); // adr write to C
        add(0, 16'h0000, 0, 0, 0, 0, 4'b0100, 0,  4'b0000, 4'b0000, 0, 0, 2, 16'hA5A5); // ack keeps data
        add(0, 16'h0001, 1, 0, 0, 1, 4'b0000, 0,  4'b0001, 4'b0000, 1, 0, 0, 16'h0001); // round robin
        add(0, 16'h0002, 1, 0, 0, 1, 4'b0001, 0,  4'b0010, 4'b0000, 2, 0, 1, 16'h0002);
        add(0, 16'h0003, 1, 0, 0, 1, 4'b0010, 0,  4'b0100, 4'b0000, 3, 0, 2, 16'h0003);
        add(0, 16'h0004, 1, 0, 0, 1, 4'b0100, 0,  4'b1000, 4'b0000, 0, 0, 3, 16'h0004); // wrap 3->0
        add(0, 16'h0005, 1, 0, 0, 1, 4'b1000, 0,  4'b0001, 4'b0000, 1, 0, 0, 16'h0005);
        add(0, 16'h0000, 0, 0, 0, 1, 4'b0001, 0,  4'b0000, 4'b0000, 1, 0, 3, 16'h0004);
        add(0, 16'h1111, 1, 0, 1, 0, 4'b0000, 0,  4'b0010, 4'b0000, 1, 0, 1, 16'h1111); // auto off, ptr held
        add(0, 16'h2222, 1, 0, 1, 0, 4'b0000, 0,  4'b0010, 4'b0010, 1, 0, 1, B_AFTER_2); // overrun
        add(0, 16'h0000, 0, 0, 0, 0, 4'b0000, 1,  4'b0010, 4'b0000, 1, 0, 1, B_AFTER_2); // ovr_clr
        add(0, 16'h3333, 1, 0, 1, 0, 4'b0000, 1,  4'b0010, 4'b0010, 1, 0, 1, B_AFTER_3); // event beats clr
        add(0, 16'h0000, 0, 0, 0, 0, 4'b0000, 1,  4'b0010, 4'b0000, 1, 0, 1, B_AFTER_3);
        add(0, 16'hDDDD, 1, 0, 3, 0, 4'b0000, 0,  4'b1010, 4'b0000, 1, 0, 3, 16'hDDDD);
        add(0, 16'hEEEE, 1, 0, 3, 0, 4'b1000, 0,  4'b1010, 4'b0000, 1, 0, 3, 16'hEEEE); // write beats ack
        add(0, 16'h0000, 0, 0, 0, 0, 4'b1010, 0,  4'b0000, 4'b0000, 1, 0, 3, 16'hEEEE); // multi ack
        add(0, 16'hFFFF, 1, 1, 0, 1, 4'b0000, 0,  4'b0000, 4'b0000, 1, 1, 0, 16'h0005); // parity errors
        add(0, 16'hFFFF, 1, 1, 0, 1, 4'b0000, 0,  4'b0000, 4'b0000, 1, 2, 0, 16'h0005);
        add(0, 16'hFFFF, 1, 1, 0, 1, 4'b0000, 0,  4'b0000, 4'b0000, 1, 3, 0, 16'h0005);
        add(0, 16'hFFFF, 1, 1, 0, 1, 4'b0000, 0,  4'b0000, 4'b0000, 1, 3, 0, 16'h0005); // saturated
        add(0, 16'hFFFF, 1, 1, 0, 1, 4'b0000, 0,  4'b0000, 4'b0000, 1, 3, 0, 16'h0005);
        add(0, 16'h1234, 1, 0, 0, 0, 4'b0000, 0,  4'b0001, 4'b0000, 1, 3, 0, 16'h1234);
        add(1, 16'h5678, 1, 0, 2, 0, 4'b0000, 0,  4'b0000, 4'b0000, 0, 0, 2, 16'h0000); // rst beats write
        add(0, 16'h0000, 0, 0, 0, 0, 4'b0000, 0,  4'b0000, 4'b0000, 0, 0, 0, 16'h0000);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].r, tbl[i].d, tbl[i].v, tbl[i].p, tbl[i].a, tbl[i].au, tbl[i].k, tbl[i].oc);
            n_vec++;
            if (bus.full !== tbl[i].e_full || bus.overrun !== tbl[i].e_ovr ||
                bus.ptr !== tbl[i].e_ptr || bus.err_cnt !== CNT_W'(tbl[i].e_err) ||
                dut_ch(tbl[i].e_ch) !== tbl[i].e_word) begin
                n_mis++;
                $display("FAIL table[%0d]: got full=%b ovr=%b ptr=%0d err=%0d ch%0d=%h; expected full=%b ovr=%b ptr=%0d err=%0d ch%0d=%h",
                         i, bus.full, bus.overrun, bus.ptr, bus.err_cnt, tbl[i].e_ch, dut_ch(tbl[i].e_ch),
                         tbl[i].e_full, tbl[i].e_ovr, tbl[i].e_ptr, tbl[i].e_err, tbl[i].e_ch, tbl[i].e_word);
            end
            check_model($sformatf("table_model[%0d]", i));
        end

        begin
            logic au_r = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                logic        r;
                logic [15:0] d;
                logic        v, p, oc;
                logic [1:0]  a;
                logic [3:0]  k;
                if ($urandom_range(0, 7) == 0) au_r = ~au_r;
                r  = ($urandom_range(0, 127) == 0);
                d  = 16'($urandom);
                v  = ($urandom_range(0, 3) != 0);
                p  = ($urandom_range(0, 7) == 0);
                a  = 2'($urandom_range(0, 3));
                k  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
                oc = ($urandom_range(0, 15) == 0);
                drive(r, d, v, p, a, au_r, k, oc);
                check_model($sformatf("random[%0d]", i));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/word_demux_1_4.md
WORD_DEMUX_1_4 -- requirements
Module: word_demux_1_4

Interface
REQ-001 Parameter: CNT_W, 8, width of parity-error counter.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous to clk, active-high.
REQ-004 din  input  16  received data word from bus decoder.
REQ-005 din_valid  input  1  single-cycle strobe; din, din_perr and adr valid this cycle.
REQ-006 din_perr  input  1  parity error on the word presented with din_valid.
REQ-007 adr  input  2  destination channel (0=A, 1=B, 2=C, 3=D) when auto=0.
REQ-008 auto  input  1  1 = internal round-robin pointer selects destination; adr ignored.
REQ-009 rd_ack  input  4  per-channel consumer acknowledge; bit n clears full[n].
REQ-010 ovr_clr  input  1  clears all overrun flags.
REQ-011 A, B, C, D  output  16 each  channel holding registers 0..3.
REQ-012 full  output  4  bit n = channel n holds an unread word.
REQ-013 overrun  output  4  sticky; bit n = write arrived while full[n]=1.
REQ-014 ptr  output  2  current round-robin pointer.
REQ-015 err_cnt  output  CNT_W  count of discarded parity-error words.

Function
REQ-016 Destination sel = ptr when auto=1, else adr.
REQ-017 Accepted word: din_valid=1 and din_perr=0; the word SHALL be written into register sel one cycle later (latency 1 clk), and full[sel] SHALL be set.
REQ-018 Parity-error word: din_valid=1 and din_perr=1; no register, full, overrun or ptr change; err_cnt +1, saturating at 2^CNT_W-1.
REQ-019 ptr SHALL increment by 1 after each accepted word when auto=1, wrapping 3->0; ptr SHALL hold when auto=0 or when the word is discarded.
REQ-020 Accepted word to a channel with full[sel]=1 and no same-cycle rd_ack[sel]: overrun[sel] set; data handling per REQ-027/028.
REQ-021 rd_ack[n]=1 with no same-cycle write to n: full[n] cleared, register n unchanged.
REQ-022 Same-cycle rd_ack[sel] and accepted write to sel: write wins; full[sel]=1, register updated, no overrun.
REQ-023 rd_ack on multiple bits in one cycle SHALL clear each acknowledged channel independently.
REQ-024 ovr_clr=1 clears all overrun bits; an overrun event in the same cycle SHALL take priority (bit remains set).
REQ-025 Switching auto 1->0 SHALL leave ptr unchanged; 0->1 resumes from held ptr.
REQ-026 din_valid=0: no state change except rd_ack/ovr_clr effects.

Configuration
REQ-027 Macro DEMUX_OVERWRITE_EN defined: overrun write replaces register contents with new word (newest kept); ptr advances.
REQ-028 Macro DEMUX_OVERWRITE_EN undefined: overrun write is dropped, register keeps old word; ptr still advances when auto=1.

Reset
REQ-029 rst=1 at a clock edge SHALL set A=B=C=D=16'h0000, full=4'b0000, overrun=4'b0000, ptr=2'd0, err_cnt=0.
REQ-030 rst SHALL dominate all same-cycle inputs, including a concurrent din_valid; a word presented with rst=1 is lost.
REQ-031 No state SHALL change without a clk edge; outputs are registered only.

Verification
REQ-032 auto=0, adr=2, din=16'hA5A5, din_valid pulse -> next cycle C=16'hA5A5, full=4'b0100, others unchanged.
REQ-033 auto=1, ptr=0, five accepted words 16'h0001..16'h0005 with rd_ack after each -> A..D = 0001..0004 then A=0005, ptr ends 1.
REQ-034 adr=1 write 16'h1111, second write 16'h2222 without ack -> overrun=4'b0010; B=16'h2222 with DEMUX_OVERWRITE_EN, B=16'h1111 without.
REQ-035 Write to adr=3 with rd_ack=4'b1000 in same cycle while full[3]=1 -> full[3]=1, D=new word, overrun[3]=0.
REQ-036 CNT_W=2, five words with din_perr=1 -> err_cnt=3 (saturated), full, ptr, registers unchanged.
REQ-037 rst asserted in cycle of din_valid after prior writes -> all outputs zero next cycle, incoming word not stored.
